// File: rtl/aes_stream_packer_pkg.sv
// Shared types for the AES stream packer: FSM states, control/flag bundles and widths.
package aes_stream_packer_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_WORD_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    CORE_REQ,
    CORE_WAIT,
    DRAIN
  } packer_state_t;

  typedef struct packed {
    logic clear;
    logic start;
  } ctrl_packer_t;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [1:0] word_cnt;
  } flags_packer_t;

endpackage

// File: rtl/aes_stream_packer_if.sv
// Control, plaintext, cipher-core and ciphertext handshakes of the stream packer.
interface aes_stream_packer_if #(
  parameter int WORD_W  = 32,
  parameter int N_WORDS = 4
);
  localparam int BLOCK_W = WORD_W * N_WORDS;

  logic               clear;
  logic               start;
  logic [WORD_W-1:0]  pt_data_i;
  logic               pt_valid_i;
  logic               pt_ready_o;
  logic [BLOCK_W-1:0] blk_data_o;
  logic               blk_valid_o;
  logic               blk_ready_i;
  logic [BLOCK_W-1:0] res_data_i;
  logic               res_valid_i;
  logic               res_ready_o;
  logic [WORD_W-1:0]  ct_data_o;
  logic               ct_valid_o;
  logic               ct_ready_i;
  logic               busy_o;
  logic               done_o;
  logic [1:0]         word_cnt_o;

  modport master (
    input  clear, start, pt_data_i, pt_valid_i, blk_ready_i, res_data_i, res_valid_i, ct_ready_i,
    output pt_ready_o, blk_data_o, blk_valid_o, res_ready_o, ct_data_o, ct_valid_o,
           busy_o, done_o, word_cnt_o
  );

  modport slave (
    output clear, start, pt_data_i, pt_valid_i, blk_ready_i, res_data_i, res_valid_i, ct_ready_i,
    input  pt_ready_o, blk_data_o, blk_valid_o, res_ready_o, ct_data_o, ct_valid_o,
           busy_o, done_o, word_cnt_o
  );
endinterface

// File: rtl/aes_word_swap.sv
// Byte-order reversal of one stream word; a plain pass-through when EN is 0.
module aes_word_swap #(
  parameter int WORD_W = 32,
  parameter bit EN     = 1'b0
) (
  input  logic [WORD_W-1:0] word,
  output logic [WORD_W-1:0] swapped
);
  generate
    if (EN) begin : g_swap
      for (genvar b = 0; b < WORD_W / 8; b++) begin : g_byte
        assign swapped[8*b +: 8] = word[WORD_W-8-8*b +: 8];
      end
    end else begin : g_pass
      assign swapped = word;
    end
  endgenerate
endmodule

// File: rtl/aes_stream_packer.sv
// Packs plaintext words into an AES block for the cipher core and serialises the
// core result back onto the ciphertext stream, one block per start pulse.
module aes_stream_packer
  import aes_stream_packer_pkg::*;
#(
  parameter int WORD_W    = AES_WORD_W,
  parameter int N_WORDS   = AES_BLOCK_W / AES_WORD_W,
  parameter bit BYTE_SWAP = 1'b0
) (
  input logic                 clk,
  input logic                 reset,
  aes_stream_packer_if.master bus
);

  packer_state_t                  state, state_n;
  logic [1:0]                     cnt, cnt_n, idx;
  logic [N_WORDS-1:0][WORD_W-1:0] blk_reg, out_reg;
  logic [WORD_W-1:0]              pt_word, ct_word;
  logic                           pt_fire, res_fire, ct_fire, last;
  ctrl_packer_t                   ctrl;
  flags_packer_t                  flags;

  assign ctrl     = '{clear: bus.clear, start: bus.start};
  // Word 0 is the most significant word of the block, so the slot index counts down.
  assign idx      = 2'(N_WORDS - 1) - cnt;
  assign last     = (cnt == 2'(N_WORDS - 1));
  assign pt_fire  = (state == FILL) && bus.pt_valid_i;
  assign res_fire = (state == CORE_WAIT) && bus.res_valid_i;
  assign ct_fire  = (state == DRAIN) && bus.ct_ready_i;

  aes_word_swap #(.WORD_W(WORD_W), .EN(BYTE_SWAP)) u_swap_in (
    .word    (bus.pt_data_i),
    .swapped (pt_word)
  );

  aes_word_swap #(.WORD_W(WORD_W), .EN(BYTE_SWAP)) u_swap_out (
    .word    (out_reg[idx]),
    .swapped (ct_word)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (ctrl.start) begin
          state_n = FILL;
          cnt_n   = '0;
        end
      end
      FILL: begin
        if (pt_fire) begin
          cnt_n = last ? 2'd0 : cnt + 2'd1;
          if (last) state_n = CORE_REQ;
        end
      end
      CORE_REQ: begin
        if (bus.blk_ready_i) state_n = CORE_WAIT;
      end
      CORE_WAIT: begin
        if (bus.res_valid_i) begin
          state_n = DRAIN;
          cnt_n   = '0;
        end
      end
      DRAIN: begin
        if (ct_fire) begin
          cnt_n = last ? 2'd0 : cnt + 2'd1;
          if (last) state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // clear behaves like reset and overrides any handshake in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (ctrl.clear) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blk_reg <= '0;
      out_reg <= '0;
    end else if (ctrl.clear) begin
      blk_reg <= '0;
      out_reg <= '0;
    end else begin
      if (pt_fire)  blk_reg[idx] <= pt_word;
      if (res_fire) out_reg      <= bus.res_data_i;
    end
  end

  assign flags = '{busy:     (state != IDLE),
                   done:     ct_fire && last && !ctrl.clear,
                   word_cnt: cnt};

  assign bus.pt_ready_o  = (state == FILL);
  assign bus.blk_valid_o = (state == CORE_REQ);
  assign bus.res_ready_o = (state == CORE_WAIT);
  assign bus.ct_valid_o  = (state == DRAIN);
  assign bus.blk_data_o  = blk_reg;
  assign bus.ct_data_o   = ct_word;
  assign bus.busy_o      = flags.busy;
  assign bus.done_o      = flags.done;
  assign bus.word_cnt_o  = flags.word_cnt;

endmodule

// File: tb/tb_aes_stream_packer.sv
// Scoreboard bench: a plain and a byte-swapping packer run in lockstep against a cipher-core model.
module tb_aes_stream_packer;

  typedef struct {
    logic [31:0] d;
    bit          last;
  } ct_exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  aes_stream_packer_if #(.WORD_W(32), .N_WORDS(4)) ifa ();
  aes_stream_packer_if #(.WORD_W(32), .N_WORDS(4)) ifb ();

  assign ifb.clear       = ifa.clear;
  assign ifb.start       = ifa.start;
  assign ifb.pt_data_i   = ifa.pt_data_i;
  assign ifb.pt_valid_i  = ifa.pt_valid_i;
  assign ifb.blk_ready_i = ifa.blk_ready_i;
  assign ifb.res_data_i  = ifa.res_data_i;
  assign ifb.res_valid_i = ifa.res_valid_i;
  assign ifb.ct_ready_i  = ifa.ct_ready_i;

  aes_stream_packer #(.WORD_W(32), .N_WORDS(4), .BYTE_SWAP(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .bus(ifa));
  aes_stream_packer #(.WORD_W(32), .N_WORDS(4), .BYTE_SWAP(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(ifb));

  int checks = 0;
  int errors = 0;

  logic [127:0] blk_q0[$], blk_q1[$];
  ct_exp_t      ct_q0[$], ct_q1[$];

  // core-model and sink configuration
  int           ready_dly = 1;
  int           res_dly   = 3;
  bit           echo      = 1'b1;
  bit           ct_rand   = 1'b0;
  logic [127:0] res_fixed = '0;
  int           ph = 0, wc = 0;
  logic [127:0] cap = '0;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] swap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // cipher core model plus block-side scoreboard check
  initial begin
    ifa.blk_ready_i = 1'b0;
    ifa.res_valid_i = 1'b0;
    ifa.res_data_i  = '0;
    forever begin
      @(negedge clk); #1;
      case (ph)
        0: if (ifa.blk_valid_o) begin
             if (wc >= ready_dly) begin
               ifa.blk_ready_i = 1'b1;
               cap = ifa.blk_data_o;
               ph = 1;
             end else wc++;
           end
        1: begin ifa.blk_ready_i = 1'b0; wc = 0; ph = 2; end
        2: if (wc >= res_dly - 1) begin
             ifa.res_valid_i = 1'b1;
             ifa.res_data_i  = echo ? cap : res_fixed;
             ph = 3;
           end else wc++;
        default: begin ifa.res_valid_i = 1'b0; wc = 0; ph = 0; end
      endcase
      if (ifa.blk_valid_o) begin
        if (blk_q0.size() == 0) chk("blk0_unexpected", ifa.blk_data_o, '0);
        else begin
          chk("blk0_data", ifa.blk_data_o, blk_q0[0]);
          if (ifa.blk_ready_i) void'(blk_q0.pop_front());
        end
      end
      if (ifb.blk_valid_o) begin
        if (blk_q1.size() == 0) chk("blk1_unexpected", ifb.blk_data_o, '0);
        else begin
          chk("blk1_data", ifb.blk_data_o, blk_q1[0]);
          if (ifb.blk_ready_i) void'(blk_q1.pop_front());
        end
      end
    end
  end

  // ciphertext sink plus ct-side scoreboard check
  initial begin
    ifa.ct_ready_i = 1'b0;
    forever begin
      @(negedge clk); #1;
      ifa.ct_ready_i = ct_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (ifa.ct_valid_o) begin
        if (ct_q0.size() == 0) chk("ct0_unexpected", ifa.ct_data_o, '0);
        else begin
          chk("ct0_data", ifa.ct_data_o, ct_q0[0].d);
          if (ifa.ct_ready_i) begin
            chk("ct0_done", ifa.done_o, ct_q0[0].last);
            void'(ct_q0.pop_front());
          end
        end
      end
      if (ifb.ct_valid_o) begin
        if (ct_q1.size() == 0) chk("ct1_unexpected", ifb.ct_data_o, '0);
        else begin
          chk("ct1_data", ifb.ct_data_o, ct_q1[0].d);
          if (ifb.ct_ready_i) begin
            chk("ct1_done", ifb.done_o, ct_q1[0].last);
            void'(ct_q1.pop_front());
          end
        end
      end
      if (ifa.done_o && !(ifa.ct_valid_o && ifa.ct_ready_i)) chk("done0_stray", ifa.done_o, 1'b0);
      if ($countones({ifa.pt_ready_o, ifa.blk_valid_o, ifa.res_ready_o, ifa.ct_valid_o}) > 1)
        chk("excl0", {ifa.pt_ready_o, ifa.blk_valid_o, ifa.res_ready_o, ifa.ct_valid_o}, 4'b0);
    end
  end

  task automatic pulse_start();
    ifa.start = 1'b1;
    @(negedge clk);
    ifa.start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    repeat (gap) @(negedge clk);
    ifa.pt_valid_i = 1'b1;
    ifa.pt_data_i  = w;
    for (int t = 0; t < 100 && !ifa.pt_ready_o; t++) @(negedge clk);
    if (!ifa.pt_ready_o) chk("pt_ready_timeout", ifa.pt_ready_o, 1'b1);
    @(negedge clk);
    ifa.pt_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((ct_q0.size() != 0 || ct_q1.size() != 0 || ifa.busy_o) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("idle_after_block", {ct_q0.size() != 0, ct_q1.size() != 0, blk_q0.size() != 0,
                             ifa.busy_o, ifb.busy_o}, '0);
  endtask

  task automatic run_block(input logic [127:0] blk, input logic [127:0] res, input bit use_echo,
                           input int maxgap, input bit start_in_done);
    logic [127:0] sw;
    logic [31:0]  d;
    echo      = use_echo;
    res_fixed = res;
    for (int i = 0; i < 4; i++) sw[127-32*i -: 32] = swap32(blk[127-32*i -: 32]);
    blk_q0.push_back(blk);
    blk_q1.push_back(sw);
    for (int i = 0; i < 4; i++) begin
      d = use_echo ? blk[127-32*i -: 32] : res[127-32*i -: 32];
      ct_q0.push_back('{d: d, last: (i == 3)});
      ct_q1.push_back('{d: swap32(d), last: (i == 3)});
    end
    pulse_start();
    for (int i = 0; i < 4; i++) send_word(blk[127-32*i -: 32], $urandom_range(0, maxgap));
    chk("fill_to_valid", {ifa.blk_valid_o, ifb.blk_valid_o}, 2'b11);
    if (start_in_done) begin
      for (int t = 0; t < 200 && !(ifa.ct_valid_o && ifa.word_cnt_o == 2'd3); t++) @(negedge clk);
      chk("reach_last_drain", {ifa.ct_valid_o, ifa.word_cnt_o}, 3'b111);
      pulse_start();
      chk("start_in_done_ignored", {ifa.busy_o, ifb.busy_o}, 2'b00);
      repeat (3) @(negedge clk);
      chk("no_second_op", {ifa.busy_o, ifa.pt_ready_o, ifb.busy_o}, 3'b000);
    end
    wait_idle();
  endtask

  initial begin
    ifa.clear = 1'b0;
    ifa.start = 1'b0;
    ifa.pt_valid_i = 1'b0;
    ifa.pt_data_i = '0;
    #3 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("reset_idle0", {ifa.pt_ready_o, ifa.blk_valid_o, ifa.res_ready_o, ifa.ct_valid_o,
                          ifa.busy_o, ifa.done_o, ifa.word_cnt_o, ifa.blk_data_o, ifa.ct_data_o}, '0);
      chk("reset_idle1", {ifb.busy_o, ifb.word_cnt_o, ifb.blk_data_o, ifb.ct_data_o}, '0);
    end

    // loopback, 1-cycle ready and 3-cycle result
    run_block(128'h00112233_44556677_8899aabb_ccddeeff, '0, 1'b1, 0, 1'b0);
    // FIPS-197 C.1 ciphertext returned by the core
    run_block(128'h00112233_44556677_8899aabb_ccddeeff,
              128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a, 1'b0, 0, 1'b0);
    // backpressure on every interface
    ready_dly = 5;
    ct_rand   = 1'b1;
    run_block(128'hdeadbeef_01234567_89abcdef_cafef00d, '0, 1'b1, 3, 1'b0);
    run_block(128'h0badc0de_11223344_55667788_99aabbcc, '0, 1'b1, 2, 1'b0);
    ready_dly = 1;
    ct_rand   = 1'b0;

    // abandon a half-filled block
    pulse_start();
    send_word(32'h1111_1111, 0);
    send_word(32'h2222_2222, 0);
    ifa.clear = 1'b1;
    @(negedge clk);
    ifa.clear = 1'b0;
    chk("clear_idle", {ifa.busy_o, ifa.pt_ready_o, ifa.word_cnt_o, ifb.busy_o}, '0);
    chk("clear_blk", ifa.blk_data_o, '0);
    run_block(128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c, '0, 1'b1, 0, 1'b0);

    // byte swap on the second instance, plus a start in the done cycle
    run_block(128'h00112233_44556677_8899aabb_ccddeeff, '0, 1'b1, 0, 1'b1);

    repeat (5) @(negedge clk);
    chk("final_queues", {blk_q0.size() != 0, blk_q1.size() != 0, ifa.busy_o}, '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
